exception_commit_ctrl: RTL and testbench
========================================

Name: exception_commit_ctrl

Overview:
- Writeback-stage exception/CP0 commit controller for an N-lane superscalar core.
- Per cycle, selects the oldest excepting or ERET lane, derives the per-lane commit mask, and drives the single CP0 write/event port.
- Owns the front-end redirect handshake, plus a drain window that suppresses wrong-path bundles after a flush.
- Lane 0 is oldest.

Parameters:
- LANES, 2: writeback lanes per bundle (1..4).
- C0_ADDR_W, 8: CP0 address width, {reg[4:0], sel[2:0]}.
- EXC_VECTOR, 32'hBFC0_0380: redirect target for exceptions and interrupts.
- EPC_ADDR, 8'd112: CP0 address of EPC (reg 14, sel 0).
- DRAIN_CYCLES, 2: cycles after redirect acceptance during which incoming bundles are discarded (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ws_valid  in  LANES  lane valid
- ws_c0_op  in  3*LANES  per lane {mfc0, mtc0, eret}
- ws_c0_addr  in  C0_ADDR_W*LANES  per-lane CP0 address
- ws_result  in  32*LANES  per-lane mtc0 write data
- ws_pc  in  32*LANES  per-lane PC
- ws_ex  in  LANES  per-lane exception flag
- ws_bd  in  LANES  per-lane branch-delay flag
- ws_exccode  in  5*LANES  per-lane exception code
- ws_badvaddr  in  32*LANES  per-lane bad virtual address
- int_pending  in  1  CP0 interrupt request, already masked
- c0_epc  in  32  current EPC value from CP0
- commit_mask  out  LANES  lanes whose results retire this cycle
- c0_we  out  1  CP0 write strobe
- c0_addr  out  C0_ADDR_W  CP0 write address
- c0_wdata  out  32  CP0 write data
- c0_ex  out  1  exception event to CP0
- c0_eret_flush  out  1  ERET event to CP0
- c0_bd  out  1  branch-delay flag of the event lane
- c0_exccode  out  5  exception code of the event
- c0_badvaddr  out  32  bad virtual address of the event
- c0_pc  out  32  PC of the event lane
- flush  out  1  kill all in-flight younger instructions (combinational, event cycle)
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  fetch redirect target
- redirect_ready  in  1  front end accepts the redirect
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, redirect_valid=0, redirect_pc=0, drain counter=0.
- All combinational outputs are 0 whenever state != IDLE.
- FSM states:
  - IDLE: normal commit.
  - REDIRECT: redirect_valid=1 until redirect_ready is seen high at a clock edge.
  - DRAIN: counts DRAIN_CYCLES, then returns to IDLE. If DRAIN_CYCLES=0, REDIRECT goes directly to IDLE.
- Interrupt: in IDLE with int_pending=1 and ws_valid[0]=1, lane 0 is treated as excepting. Interrupt overrides lane 0's own exception: exccode=0, badvaddr=0, bd=ws_bd[0].
- Event lane k: the lowest index with valid & (ex | eret). Exception has priority over ERET within the same lane.
- Commit mask:
  - Set for every valid lane with index < k.
  - Also set for lane k if its event is ERET.
  - Lanes > k are never committed.
  - With no event, commit_mask = ws_valid.
- Event cycle T:
  - flush=1.
  - Exactly one of c0_ex / c0_eret_flush is 1.
  - c0_bd, c0_exccode, c0_badvaddr and c0_pc are taken from lane k.
  - At the T edge: state goes to REDIRECT and redirect_pc is registered.
- redirect_pc:
  - Exception: EXC_VECTOR.
  - ERET: c0_epc, except when a committed lane < k does mtc0 to EPC_ADDR in the same cycle; then that lane's ws_result is forwarded.
- CP0 write:
  - c0_we=1 for the lowest-index committed lane with mtc0 and not ex; c0_addr/c0_wdata come from that lane.
  - At most one mtc0 per bundle is an issue rule. A simulation assertion fires if more than one committed lane has mtc0.
- mfc0 carries no CP0 side effects here.
- redirect_valid and redirect_pc are held stable until accepted. Bundles arriving in REDIRECT or DRAIN are discarded: no commit, no event.
- Reset asserted mid-REDIRECT or mid-DRAIN: returns to IDLE immediately, redirect_valid drops asynchronously.

Optional Feature:
- Macro: EXC_COMMIT_STATS_EN.
- With the macro defined, the block adds these outputs, each cleared by reset:
  - exc_count out 32: increments on each c0_ex.
  - eret_count out 32: increments on each c0_eret_flush.
  - last_exccode out 5: records c0_exccode at each exception.
  - Both counters wrap from 32'hFFFF_FFFF to 0.
- Without the macro, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Full commit: LANES=2, both lanes valid, no ex, lane1 mtc0 addr 8'd96 data 32'h1234 -> commit_mask=2'b11, c0_we=1, c0_addr=96, c0_wdata=32'h1234, flush=0.
- Exception in lane 1: lane1 ex exccode 5'h04 badvaddr 32'h0000_0003 pc 32'h8000_0104 -> commit_mask=2'b01, c0_ex=1, c0_pc=32'h8000_0104, c0_badvaddr=3. Next cycle redirect_valid=1, redirect_pc=32'hBFC0_0380.
- ERET with forwarding: lane0 mtc0 EPC data 32'h8000_2000, lane1 eret, c0_epc=32'h8000_1000 -> commit_mask=2'b11, c0_eret_flush=1, redirect_pc=32'h8000_2000.
- Interrupt with backpressure: int_pending=1, lane0 valid with its own ex exccode 5'h0A -> c0_exccode=0, commit_mask=0. Hold redirect_ready=0 for 3 cycles -> redirect_valid stays 1 and redirect_pc stays stable.
- Drain: after acceptance, present valid bundles with ex=1 for 2 cycles -> no c0_ex, commit_mask=0, busy=1. Cycle 3 -> normal commit, busy=0.
- Reset in REDIRECT: assert reset mid-REDIRECT -> redirect_valid=0 without waiting for a clock edge; with EXC_COMMIT_STATS_EN, exc_count=0.

Source files
------------

// File: rtl/exception_commit_ctrl.sv
// ---------------------------------------------------------------------------
// exception_commit_ctrl
//
// Writeback-stage exception / CP0 commit controller for an N-lane
// superscalar core. Lane 0 is the oldest lane of a bundle.
//
// Each cycle in IDLE it:
//   - finds the oldest lane carrying an exception (or an interrupt taken on
//     lane 0) or an ERET,
//   - retires every valid lane older than that event (plus the ERET lane
//     itself),
//   - drives the single CP0 write/event port,
//   - flushes younger work and registers a fetch redirect.
// After the redirect is accepted, a drain window discards wrong-path bundles.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ws_*                per-lane writeback bundle (valid, {mfc0,mtc0,eret},
//                       CP0 address, mtc0 data, PC, ex, bd, exccode,
//                       badvaddr)
//   int_pending         masked CP0 interrupt request
//   c0_epc              current EPC value
//   commit_mask         lanes retiring this cycle
//   c0_we/addr/wdata    CP0 register write port
//   c0_ex, c0_eret_flush, c0_bd, c0_exccode, c0_badvaddr, c0_pc
//                       CP0 event port
//   flush               kill younger in-flight work (event cycle)
//   redirect_valid/pc/ready   front-end redirect handshake
//   busy                controller is not in IDLE
//
// Optional feature (macro EXC_COMMIT_STATS_EN): adds exc_count,
// eret_count and last_exccode statistics outputs.
// ---------------------------------------------------------------------------
module exception_commit_ctrl #(
  parameter int                    LANES        = 2,
  parameter int                    C0_ADDR_W    = 8,
  parameter logic [31:0]           EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [C0_ADDR_W-1:0]  EPC_ADDR     = C0_ADDR_W'(112),
  parameter int                    DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES-1:0]           ws_valid,
  input  logic [3*LANES-1:0]         ws_c0_op,
  input  logic [C0_ADDR_W*LANES-1:0] ws_c0_addr,
  input  logic [32*LANES-1:0]        ws_result,
  input  logic [32*LANES-1:0]        ws_pc,
  input  logic [LANES-1:0]           ws_ex,
  input  logic [LANES-1:0]           ws_bd,
  input  logic [5*LANES-1:0]         ws_exccode,
  input  logic [32*LANES-1:0]        ws_badvaddr,
  input  logic                       int_pending,
  input  logic [31:0]                c0_epc,
  output logic [LANES-1:0]           commit_mask,
  output logic                       c0_we,
  output logic [C0_ADDR_W-1:0]       c0_addr,
  output logic [31:0]                c0_wdata,
  output logic                       c0_ex,
  output logic                       c0_eret_flush,
  output logic                       c0_bd,
  output logic [4:0]                 c0_exccode,
  output logic [31:0]                c0_badvaddr,
  output logic [31:0]                c0_pc,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  input  logic                       redirect_ready,
  output logic                       busy
`ifdef EXC_COMMIT_STATS_EN
  ,
  output logic [31:0]                exc_count,
  output logic [31:0]                eret_count,
  output logic [4:0]                 last_exccode
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDIRECT,
    ST_DRAIN
  } state_e;

  // The drain counter is loaded with DRAIN_CYCLES-1 so that exactly
  // DRAIN_CYCLES cycles are spent in ST_DRAIN.
  localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;

  logic             ev_found, ev_is_ex, lane_ex, lane_eret, irq_lane0;
  logic [2:0]       ev_idx, we_idx;
  logic             we_found;
  logic [LANES-1:0] mtc0_commit;
  logic [31:0]      ev_target;

  // mfc0 has no side effects in this block; the opcode bus is only partly used.
  logic unused_op_bits;
  assign unused_op_bits = ^ws_c0_op;

  // Event selection and commit mask. Only IDLE looks at the bundle, so any
  // bundle arriving in REDIRECT/DRAIN is dropped with all outputs at zero.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    commit_mask = '0;
    ev_found    = 1'b0;
    ev_is_ex    = 1'b0;
    ev_idx      = '0;
    lane_ex     = 1'b0;
    lane_eret   = 1'b0;
    c0_bd       = 1'b0;
    c0_exccode  = '0;
    c0_badvaddr = '0;
    c0_pc       = '0;
    irq_lane0   = int_pending && ws_valid[0];
    if (state_q == ST_IDLE) begin
      for (int i = 0; i < LANES; i++) begin
        if (!ev_found) begin
          // An interrupt is taken on lane 0 by treating it as excepting.
          lane_ex   = ws_valid[i] && (ws_ex[i] || (i == 0 && int_pending));
          lane_eret = ws_valid[i] && ws_c0_op[3*i];
          if (lane_ex || lane_eret) begin
            ev_found       = 1'b1;
            ev_is_ex       = lane_ex;
            ev_idx         = 3'(i);
            commit_mask[i] = !lane_ex;  // ERET lane retires, excepting lane does not
            c0_bd          = ws_bd[i];
            c0_pc          = ws_pc[32*i +: 32];
            if (!(i == 0 && irq_lane0)) begin
              c0_exccode  = ws_exccode[5*i +: 5];
              c0_badvaddr = ws_badvaddr[32*i +: 32];
            end
          end else begin
            commit_mask[i] = ws_valid[i];
          end
        end
      end
    end
  end

  // CP0 write port: lowest committed lane doing mtc0.
  always_comb begin
    c0_we       = 1'b0;
    c0_addr     = '0;
    c0_wdata    = '0;
    we_found    = 1'b0;
    we_idx      = '0;
    mtc0_commit = '0;
    for (int i = 0; i < LANES; i++) begin
      mtc0_commit[i] = commit_mask[i] && ws_c0_op[3*i+1] && !ws_ex[i];
      if (mtc0_commit[i] && !we_found) begin
        we_found = 1'b1;
        we_idx   = 3'(i);
        c0_we    = 1'b1;
        c0_addr  = ws_c0_addr[C0_ADDR_W*i +: C0_ADDR_W];
        c0_wdata = ws_result[32*i +: 32];
      end
    end
  end

  assign flush         = ev_found;
  assign c0_ex         = ev_found && ev_is_ex;
  assign c0_eret_flush = ev_found && !ev_is_ex;

  // An older lane writing EPC in the ERET bundle must win over the stale
  // CP0 value, since CP0 only sees that write at the end of this cycle.
  assign ev_target = ev_is_ex ? EXC_VECTOR :
                     (we_found && (c0_addr == EPC_ADDR) && (we_idx < ev_idx)) ? c0_wdata :
                     c0_epc;

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    drain_cnt_d      = drain_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ev_found) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = ev_target;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          redirect_valid_d = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 4'd0) state_d = ST_IDLE;
        else                     drain_cnt_d = drain_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      drain_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      drain_cnt_q      <= drain_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = (state_q != ST_IDLE);

  // Issue guarantees at most one mtc0 per retired bundle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mtc0_single: assert ($countones(mtc0_commit) <= 1);
    end
  end

`ifdef EXC_COMMIT_STATS_EN
  logic [31:0] exc_count_q, exc_count_d;
  logic [31:0] eret_count_q, eret_count_d;
  logic [4:0]  last_exccode_q, last_exccode_d;

  always_comb begin
    exc_count_d    = exc_count_q;
    eret_count_d   = eret_count_q;
    last_exccode_d = last_exccode_q;
    if (c0_ex) begin
      exc_count_d    = exc_count_q + 32'd1;  // wraps naturally
      last_exccode_d = c0_exccode;
    end
    if (c0_eret_flush) eret_count_d = eret_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_count_q    <= '0;
      eret_count_q   <= '0;
      last_exccode_q <= '0;
    end else begin
      exc_count_q    <= exc_count_d;
      eret_count_q   <= eret_count_d;
      last_exccode_q <= last_exccode_d;
    end
  end

  assign exc_count    = exc_count_q;
  assign eret_count   = eret_count_q;
  assign last_exccode = last_exccode_q;
`endif

endmodule

// File: tb/tb_exception_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exception_commit_ctrl
//
// Self-checking bench for exception_commit_ctrl (LANES=2). Directed steps
// follow the intended use cases, then a randomized run compares every output
// each cycle against a behavioural model that reasons about the bundle as an
// ordered list of instructions retiring oldest-first until the first event.
// ---------------------------------------------------------------------------
module tb_exception_commit_ctrl;

  localparam int          LANES    = 2;
  localparam int          AW       = 8;
  localparam logic [31:0] EXC_VEC  = 32'hBFC0_0380;
  localparam logic [7:0]  EPC      = 8'd112;
  localparam int          DRAIN    = 2;
  localparam logic [2:0]  OP_NONE  = 3'b000;
  localparam logic [2:0]  OP_ERET  = 3'b001;
  localparam logic [2:0]  OP_MTC0  = 3'b010;
  localparam logic [2:0]  OP_MFC0  = 3'b100;

  logic                  clk, reset;
  logic [LANES-1:0]      ws_valid, ws_ex, ws_bd;
  logic [3*LANES-1:0]    ws_c0_op;
  logic [AW*LANES-1:0]   ws_c0_addr;
  logic [32*LANES-1:0]   ws_result, ws_pc, ws_badvaddr;
  logic [5*LANES-1:0]    ws_exccode;
  logic                  int_pending;
  logic [31:0]           c0_epc;
  logic [LANES-1:0]      commit_mask;
  logic                  c0_we, c0_ex, c0_eret_flush, c0_bd, flush;
  logic [AW-1:0]         c0_addr;
  logic [31:0]           c0_wdata, c0_badvaddr, c0_pc;
  logic [4:0]            c0_exccode;
  logic                  redirect_valid, redirect_ready, busy;
  logic [31:0]           redirect_pc;
`ifdef EXC_COMMIT_STATS_EN
  logic [31:0]           exc_count, eret_count;
  logic [4:0]            last_exccode;
`endif

  exception_commit_ctrl #(
    .LANES(LANES), .C0_ADDR_W(AW), .EXC_VECTOR(EXC_VEC),
    .EPC_ADDR(EPC), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .reset(reset),
    .ws_valid(ws_valid), .ws_c0_op(ws_c0_op), .ws_c0_addr(ws_c0_addr),
    .ws_result(ws_result), .ws_pc(ws_pc), .ws_ex(ws_ex), .ws_bd(ws_bd),
    .ws_exccode(ws_exccode), .ws_badvaddr(ws_badvaddr),
    .int_pending(int_pending), .c0_epc(c0_epc),
    .commit_mask(commit_mask), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_ex(c0_ex), .c0_eret_flush(c0_eret_flush),
    .c0_bd(c0_bd), .c0_exccode(c0_exccode), .c0_badvaddr(c0_badvaddr),
    .c0_pc(c0_pc), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
`ifdef EXC_COMMIT_STATS_EN
    , .exc_count(exc_count), .eret_count(eret_count), .last_exccode(last_exccode)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_rv;
  logic [31:0] m_rpc;
  int          m_drain;
  logic [31:0] m_exc_cnt, m_eret_cnt;
  logic [4:0]  m_last_code;

  logic [LANES-1:0] e_commit;
  logic             e_we, e_ex, e_eret, e_bd, e_flush;
  logic [AW-1:0]    e_addr;
  logic [31:0]      e_wdata, e_bva, e_pc, e_target;
  logic [4:0]       e_code;

  task automatic model_reset();
    m_rv = 0; m_rpc = '0; m_drain = 0;
    m_exc_cnt = '0; m_eret_cnt = '0; m_last_code = '0;
  endtask

  task automatic model_eval();
    int k, w;
    bit k_ex, exc, er;
    e_commit = '0; e_we = 0; e_addr = '0; e_wdata = '0; e_ex = 0; e_eret = 0;
    e_bd = 0; e_code = '0; e_bva = '0; e_pc = '0; e_flush = 0; e_target = '0;
    if (!m_rv && m_drain == 0) begin
      // Walk the bundle oldest-first; the first exception/ERET stops retirement.
      k = LANES; k_ex = 0;
      for (int i = 0; i < LANES; i++) begin
        exc = ws_valid[i] && (ws_ex[i] || (i == 0 && int_pending));
        er  = ws_valid[i] && ws_c0_op[3*i];
        if (exc || er) begin k = i; k_ex = exc; break; end
      end
      for (int i = 0; i < LANES; i++)
        e_commit[i] = ws_valid[i] && (i < k || (i == k && !k_ex));
      w = -1;
      for (int i = 0; i < LANES; i++)
        if (e_commit[i] && ws_c0_op[3*i+1] && !ws_ex[i]) begin w = i; break; end
      if (w >= 0) begin
        e_we = 1; e_addr = ws_c0_addr[AW*w +: AW]; e_wdata = ws_result[32*w +: 32];
      end
      if (k < LANES) begin
        e_flush = 1; e_ex = k_ex; e_eret = !k_ex;
        e_bd = ws_bd[k]; e_pc = ws_pc[32*k +: 32];
        if (k == 0 && k_ex && int_pending) begin
          e_code = 5'd0; e_bva = 32'd0;
        end else begin
          e_code = ws_exccode[5*k +: 5]; e_bva = ws_badvaddr[32*k +: 32];
        end
        if (k_ex) e_target = EXC_VEC;
        else if (w >= 0 && w < k && e_addr == EPC) e_target = e_wdata;
        else e_target = c0_epc;
      end
    end
  endtask

  task automatic model_advance();
    if (m_rv) begin
      if (redirect_ready) begin m_rv = 0; m_drain = DRAIN; end
    end else if (m_drain > 0) begin
      m_drain--;
    end else if (e_flush) begin
      m_rv = 1; m_rpc = e_target;
      if (e_ex) begin m_exc_cnt++; m_last_code = e_code; end
      else m_eret_cnt++;
    end
  endtask

  task automatic check_all();
    check("commit_mask", 32'(commit_mask), 32'(e_commit));
    check("c0_we", 32'(c0_we), 32'(e_we));
    check("c0_addr", 32'(c0_addr), 32'(e_addr));
    check("c0_wdata", c0_wdata, e_wdata);
    check("c0_ex", 32'(c0_ex), 32'(e_ex));
    check("c0_eret_flush", 32'(c0_eret_flush), 32'(e_eret));
    check("c0_bd", 32'(c0_bd), 32'(e_bd));
    check("c0_exccode", 32'(c0_exccode), 32'(e_code));
    check("c0_badvaddr", c0_badvaddr, e_bva);
    check("c0_pc", c0_pc, e_pc);
    check("flush", 32'(flush), 32'(e_flush));
    check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    check("redirect_pc", redirect_pc, m_rpc);
    check("busy", 32'(busy), 32'(m_rv || m_drain > 0));
`ifdef EXC_COMMIT_STATS_EN
    check("exc_count", exc_count, m_exc_cnt);
    check("eret_count", eret_count, m_eret_cnt);
    check("last_exccode", 32'(last_exccode), 32'(m_last_code));
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_bundle();
    ws_valid = '0; ws_ex = '0; ws_bd = '0; ws_c0_op = '0; ws_c0_addr = '0;
    ws_result = '0; ws_pc = '0; ws_exccode = '0; ws_badvaddr = '0;
    int_pending = 0;
  endtask

  task automatic set_lane(input int i, input bit v, input logic [2:0] op,
                          input logic [7:0] addr, input logic [31:0] res,
                          input logic [31:0] pc, input bit ex, input bit bd,
                          input logic [4:0] code, input logic [31:0] bva);
    ws_valid[i] = v; ws_c0_op[3*i +: 3] = op; ws_c0_addr[AW*i +: AW] = addr;
    ws_result[32*i +: 32] = res; ws_pc[32*i +: 32] = pc; ws_ex[i] = ex;
    ws_bd[i] = bd; ws_exccode[5*i +: 5] = code; ws_badvaddr[32*i +: 32] = bva;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic settle();
    #1;
    model_eval();
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] op;
    bit         mtc0_used;
    reset = 1; redirect_ready = 0; c0_epc = '0;
    clear_bundle();
    model_reset();
    @(negedge clk);
    settle();
    check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
    reset = 0;
    @(negedge clk);

    // Full commit with a CP0 write from lane 1.
    set_lane(0, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0100, 0, 0, 5'd0, 32'd0);
    set_lane(1, 1, OP_MTC0, 8'd96, 32'h1234, 32'h8000_0104, 0, 0, 5'd0, 32'd0);
    settle();
    check("tp_full_mask", 32'(commit_mask), 32'h3);
    check("tp_full_we", 32'(c0_we), 32'd1);
    check("tp_full_addr", 32'(c0_addr), 32'd96);
    check("tp_full_wdata", c0_wdata, 32'h1234);
    check("tp_full_flush", 32'(flush), 32'd0);
    tick();

    // Exception in lane 1.
    clear_bundle();
    set_lane(0, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0100, 0, 0, 5'd0, 32'd0);
    set_lane(1, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0104, 1, 0, 5'h04, 32'h3);
    settle();
    check("tp_exc_mask", 32'(commit_mask), 32'h1);
    check("tp_exc_ex", 32'(c0_ex), 32'd1);
    check("tp_exc_pc", c0_pc, 32'h8000_0104);
    check("tp_exc_bva", c0_badvaddr, 32'h3);
    tick();
    clear_bundle();
    redirect_ready = 1;
    settle();
    check("tp_exc_rv", 32'(redirect_valid), 32'd1);
    check("tp_exc_rpc", redirect_pc, 32'hBFC0_0380);
    tick();
    redirect_ready = 0;
    repeat (DRAIN) begin settle(); tick(); end

    // ERET with EPC forwarded from an older mtc0, then the drain window.
    set_lane(0, 1, OP_MTC0, EPC, 32'h8000_2000, 32'h8000_0200, 0, 0, 5'd0, 32'd0);
    set_lane(1, 1, OP_ERET, 8'd0, 32'h0, 32'h8000_0204, 0, 0, 5'd0, 32'd0);
    c0_epc = 32'h8000_1000;
    settle();
    check("tp_eret_mask", 32'(commit_mask), 32'h3);
    check("tp_eret_flag", 32'(c0_eret_flush), 32'd1);
    tick();
    clear_bundle();
    redirect_ready = 1;
    settle();
    check("tp_eret_rpc", redirect_pc, 32'h8000_2000);
    tick();
    redirect_ready = 0;
    set_lane(0, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0300, 1, 0, 5'h0C, 32'd0);
    set_lane(1, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0304, 1, 0, 5'h0C, 32'd0);
    repeat (DRAIN) begin
      settle();
      check("tp_drain_ex", 32'(c0_ex), 32'd0);
      check("tp_drain_mask", 32'(commit_mask), 32'd0);
      check("tp_drain_busy", 32'(busy), 32'd1);
      tick();
    end
    clear_bundle();
    set_lane(0, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0400, 0, 0, 5'd0, 32'd0);
    set_lane(1, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0404, 0, 0, 5'd0, 32'd0);
    settle();
    check("tp_post_drain_mask", 32'(commit_mask), 32'h3);
    check("tp_post_drain_busy", 32'(busy), 32'd0);
    tick();

    // Interrupt overriding lane 0's own exception, with backpressure.
    clear_bundle();
    int_pending = 1;
    set_lane(0, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0500, 1, 1, 5'h0A, 32'h55);
    set_lane(1, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0504, 0, 0, 5'd0, 32'd0);
    settle();
    check("tp_irq_code", 32'(c0_exccode), 32'd0);
    check("tp_irq_mask", 32'(commit_mask), 32'd0);
    check("tp_irq_bd", 32'(c0_bd), 32'd1);
    tick();
    clear_bundle();
    repeat (3) begin
      settle();
      check("tp_bp_rv", 32'(redirect_valid), 32'd1);
      check("tp_bp_rpc", redirect_pc, 32'hBFC0_0380);
      tick();
    end
    redirect_ready = 1;
    settle(); tick();
    redirect_ready = 0;
    repeat (DRAIN) begin settle(); tick(); end

    // Reset while waiting in REDIRECT drops redirect_valid immediately.
    set_lane(0, 1, OP_NONE, 8'd0, 32'h0, 32'h8000_0600, 1, 0, 5'h05, 32'h44);
    settle(); tick();
    clear_bundle();
    settle();
    reset = 1;
    #1;
    check("tp_rst_rv", 32'(redirect_valid), 32'd0);
    check("tp_rst_busy", 32'(busy), 32'd0);
`ifdef EXC_COMMIT_STATS_EN
    check("tp_rst_exc_count", exc_count, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    reset = 0;

    // Randomized traffic against the model (at most one mtc0 per bundle).
    for (int n = 0; n < 600; n++) begin
      clear_bundle();
      mtc0_used = 0;
      for (int i = 0; i < LANES; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    op = OP_ERET;
          2, 3, 4: op = mtc0_used ? OP_MFC0 : OP_MTC0;
          5:       op = OP_MFC0;
          default: op = OP_NONE;
        endcase
        if (op == OP_MTC0) mtc0_used = 1;
        set_lane(i, ($urandom_range(0, 9) < 8), op,
                 ($urandom_range(0, 1) == 1) ? EPC : 8'($urandom),
                 $urandom, $urandom, ($urandom_range(0, 9) < 2),
                 1'($urandom), 5'($urandom), $urandom);
      end
      int_pending    = ($urandom_range(0, 9) == 0);
      c0_epc         = $urandom;
      redirect_ready = 1'($urandom);
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard bound on run time in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
